// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive FSM slice.
//   DATA_WIDTH_DEFAULT : default serial data bits per frame
//   PRESCALE_8/16/32   : legal oversampling ratios
//   state_e            : receiver FSM states
//   expected_parity    : parity bit value a correct frame carries
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned PRESCALE_W         = 6;
  localparam int unsigned EDGE_W             = 5;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Even parity: bit equals XOR of data; odd parity: its complement.
  function automatic logic expected_parity(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Receiver-side bus of the UART RX FSM.
//   master : drives serial line, config and sampler strobes (line/sampler side)
//   slave  : the receiver FSM; drives sampler enable, edge index and results
interface uart_rx_fsm_if
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
);

  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  dat_samp_en;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output rx_in, prescale, par_en, par_typ, sampled_bit, sample_valid,
    input  dat_samp_en, edge_cnt, p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ, sampled_bit, sample_valid,
    output dat_samp_en, edge_cnt, p_data, data_valid, par_err, stp_err
  );

endinterface

// File: rtl/edge_bit_counter.sv
// Oversample edge counter and bit-period counter for the UART receiver.
//   enable   : count while high, clear both counters while low
//   prescale : latched oversampling ratio
//   edge_cnt : oversample index within the current bit
//   bit_cnt  : completed bit periods since the frame started
//   wrap     : last oversample of the current bit period
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned BIT_CNT_W = 4
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  wrap
);

  localparam logic [EDGE_W-1:0] EDGE_MAX = '1;

  // Counter saturation also wraps, so illegal ratios (0, >32) cannot lock the frame up.
  always_comb begin
    wrap = ({1'b0, edge_cnt} == (prescale - PRESCALE_W'(1))) || (edge_cnt == EDGE_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: frame sequencing, LSB-first shift register,
// parity/stop checking and registered result strobes.
//   clk, reset_n : clock (prescale x bit rate), async active-low reset
//   bus          : slave side of uart_rx_fsm_if (line, config, sampler
//                  handshake, received byte and strobes)
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
)(
  input  logic         clk,
  input  logic         reset_n,
  uart_rx_fsm_if.slave bus
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 3);

  state_e                state;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_flag;
  logic                  stp_flag;
  logic                  rx_armed;
  logic                  dat_samp_en;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  logic [EDGE_W-1:0]     edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  wrap;

  logic                  glitch_c;
  logic                  stop_end_c;
  logic                  stp_now_c;
  logic                  exp_par_c;
  logic                  cnt_en_c;

  // Frame-level decode; counters are cleared on the same edge the FSM returns to IDLE.
  always_comb begin
    glitch_c   = (state == START) && bus.sample_valid && bus.sampled_bit;
    stop_end_c = (state == STOP) && wrap;
    stp_now_c  = stp_flag || (bus.sample_valid && !bus.sampled_bit);
    exp_par_c  = expected_parity(^shift_reg, par_typ_q);
    cnt_en_c   = (state != IDLE) && !glitch_c && !stop_end_c;
  end

  edge_bit_counter #(
    .BIT_CNT_W (BIT_CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (cnt_en_c),
    .prescale (prescale_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .wrap     (wrap)
  );

  // Receiver FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      prescale_q  <= PRESCALE_16;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      shift_reg   <= '0;
      p_data      <= '0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      rx_armed    <= 1'b0;
      dat_samp_en <= 1'b0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      // A start needs the line to have been seen high since reset.
      rx_armed   <= rx_armed | bus.rx_in;

      unique case (state)
        IDLE: begin
          par_flag <= 1'b0;
          stp_flag <= 1'b0;
          if (rx_armed && !bus.rx_in) begin
            state       <= START;
            dat_samp_en <= 1'b1;
            prescale_q  <= bus.prescale;
            par_en_q    <= bus.par_en;
            par_typ_q   <= bus.par_typ;
          end
        end

        START: begin
          if (glitch_c) begin
            state       <= IDLE;
            dat_samp_en <= 1'b0;
          end else if (wrap) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (bus.sample_valid) begin
            shift_reg <= DATA_WIDTH'({bus.sampled_bit, shift_reg} >> 1);
          end
          if (wrap && (bit_cnt == BIT_CNT_W'(DATA_WIDTH))) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end

        PARITY: begin
          if (bus.sample_valid && (bus.sampled_bit != exp_par_c)) begin
            par_flag <= 1'b1;
          end
          if (wrap) begin
            state <= STOP;
          end
        end

        STOP: begin
          if (bus.sample_valid && !bus.sampled_bit) begin
            stp_flag <= 1'b1;
          end
          if (wrap) begin
            state       <= IDLE;
            dat_samp_en <= 1'b0;
            par_flag    <= 1'b0;
            stp_flag    <= 1'b0;
            if (par_flag || stp_now_c) begin
              par_err <= par_flag;
              stp_err <= stp_now_c;
            end else begin
              data_valid <= 1'b1;
              p_data     <= shift_reg;
            end
          end
        end

        default: begin
          state       <= IDLE;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dat_samp_en = dat_samp_en;
  assign bus.edge_cnt    = edge_cnt;
  assign bus.p_data      = p_data;
  assign bus.data_valid  = data_valid;
  assign bus.par_err     = par_err;
  assign bus.stp_err     = stp_err;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm: drives serial frames, acts as the mid-bit
// sampling stage, and checks strobes, received data and frame timing
// against a frame-level reference model.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  localparam int unsigned DW = 8;

  logic clk;
  logic reset_n;

  uart_rx_fsm_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned n_cmp;
  int unsigned n_fail;

  // Written by the main sequence only.
  int unsigned   samp_ps;
  logic          idle_noise;
  logic [DW-1:0] model_p_data;

  // Written by the monitor/sampler only.
  int unsigned   cyc;
  int unsigned   dv_total;
  int unsigned   pe_total;
  int unsigned   se_total;
  int unsigned   dv_cyc;
  int unsigned   start_cyc;
  logic [DW-1:0] dv_log [0:255];
  logic          prev_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor (records strobes and start entries) and mid-bit sampler.
  initial begin
    cyc = 0; dv_total = 0; pe_total = 0; se_total = 0;
    dv_cyc = 0; start_cyc = 0; prev_en = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sampled_bit  = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.data_valid === 1'b1) begin
        dv_log[dv_total[7:0]] = bus.p_data;
        dv_total++;
        dv_cyc = cyc;
      end
      if (bus.par_err === 1'b1) pe_total++;
      if (bus.stp_err === 1'b1) se_total++;
      if (bus.dat_samp_en === 1'b1 && prev_en !== 1'b1) start_cyc = cyc;
      prev_en = bus.dat_samp_en;
      if (bus.dat_samp_en === 1'b1) begin
        bus.sample_valid = (bus.edge_cnt == 5'(samp_ps / 2));
        bus.sampled_bit  = bus.rx_in;
      end else if (idle_noise) begin
        bus.sample_valid = 1'($urandom);
        bus.sampled_bit  = 1'($urandom);
      end else begin
        bus.sample_valid = 1'b0;
      end
    end
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int unsigned ps);
    bus.rx_in = b;
    repeat (ps) @(negedge clk);
  endtask

  // Parity bit a correct frame carries: makes total ones even (pt=0) or odd (pt=1).
  function automatic logic good_parity(input logic [DW-1:0] d, input logic pt);
    return 1'(($countones(d) + int'(pt)) % 2);
  endfunction

  // One frame on the line; scramble perturbs config inputs after the start bit.
  task automatic send_frame(input logic [DW-1:0] d, input int unsigned ps,
                            input logic pe, input logic pt, input logic flip_par,
                            input logic stop, input logic scramble);
    samp_ps      = ps;
    bus.prescale = 6'(ps);
    bus.par_en   = pe;
    bus.par_typ  = pt;
    drive_bit(1'b0, ps);
    if (scramble) begin
      bus.prescale = 6'($urandom_range(0, 63));
      bus.par_en   = 1'($urandom);
      bus.par_typ  = 1'($urandom);
    end
    for (int i = 0; i < int'(DW); i++) drive_bit(d[i], ps);
    if (pe) drive_bit(good_parity(d, pt) ^ flip_par, ps);
    drive_bit(stop, ps);
    bus.rx_in = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.rx_in = 1'b0;
    wait_cycles(3);
    n_cmp++; if (bus.dat_samp_en !== 1'b0) begin n_fail++; $display("FAIL reset dat_samp_en: got %b expected 0", bus.dat_samp_en); end
    n_cmp++; if (bus.edge_cnt !== 5'd0) begin n_fail++; $display("FAIL reset edge_cnt: got %0d expected 0", bus.edge_cnt); end
    n_cmp++; if (bus.p_data !== 8'h00) begin n_fail++; $display("FAIL reset p_data: got %0h expected 0", bus.p_data); end
    n_cmp++; if ({bus.data_valid, bus.par_err, bus.stp_err} !== 3'b000) begin n_fail++; $display("FAIL reset strobes: got %b expected 000", {bus.data_valid, bus.par_err, bus.stp_err}); end
    // Line held low across reset release must not start a frame.
    reset_n = 1'b1;
    wait_cycles(20);
    n_cmp++; if (bus.dat_samp_en !== 1'b0) begin n_fail++; $display("FAIL reset no_fresh_edge: dat_samp_en got %b expected 0", bus.dat_samp_en); end
    bus.rx_in = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_no_parity;
    int unsigned b_dv, b_pe, b_se;
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_cycles(6);
    model_p_data = 8'hA5;
    n_cmp++; if (dv_total - b_dv !== 1) begin n_fail++; $display("FAIL nopar data_valid count: got %0d expected 1", dv_total - b_dv); end
    n_cmp++; if ((pe_total - b_pe) + (se_total - b_se) !== 0) begin n_fail++; $display("FAIL nopar error strobes: got %0d expected 0", (pe_total - b_pe) + (se_total - b_se)); end
    n_cmp++; if (bus.p_data !== model_p_data) begin n_fail++; $display("FAIL nopar p_data: got %0h expected %0h", bus.p_data, model_p_data); end
    n_cmp++; if (dv_cyc - start_cyc !== 80) begin n_fail++; $display("FAIL nopar latency: got %0d expected 80", dv_cyc - start_cyc); end
    n_cmp++; if (bus.dat_samp_en !== 1'b0) begin n_fail++; $display("FAIL nopar back_to_idle: dat_samp_en got %b expected 0", bus.dat_samp_en); end
  endtask

  task automatic test_parity;
    int unsigned b_dv, b_pe, b_se;
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_cycles(6);
    model_p_data = 8'h3C;
    n_cmp++; if (dv_total - b_dv !== 1 || pe_total - b_pe !== 0) begin n_fail++; $display("FAIL even_ok strobes: dv %0d pe %0d expected dv 1 pe 0", dv_total - b_dv, pe_total - b_pe); end
    n_cmp++; if (bus.p_data !== model_p_data) begin n_fail++; $display("FAIL even_ok p_data: got %0h expected %0h", bus.p_data, model_p_data); end
    n_cmp++; if (dv_cyc - start_cyc !== 11 * 16) begin n_fail++; $display("FAIL even_ok latency: got %0d expected %0d", dv_cyc - start_cyc, 11 * 16); end
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_cycles(6);
    n_cmp++; if (pe_total - b_pe !== 1) begin n_fail++; $display("FAIL even_bad par_err count: got %0d expected 1", pe_total - b_pe); end
    n_cmp++; if (dv_total - b_dv !== 0 || se_total - b_se !== 0) begin n_fail++; $display("FAIL even_bad other strobes: dv %0d se %0d expected 0 0", dv_total - b_dv, se_total - b_se); end
    n_cmp++; if (bus.p_data !== model_p_data) begin n_fail++; $display("FAIL even_bad p_data held: got %0h expected %0h", bus.p_data, model_p_data); end
  endtask

  task automatic test_stop_err;
    int unsigned b_dv, b_pe, b_se;
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_cycles(6);
    n_cmp++; if (se_total - b_se !== 1) begin n_fail++; $display("FAIL stop_err count: got %0d expected 1", se_total - b_se); end
    n_cmp++; if (dv_total - b_dv !== 0 || pe_total - b_pe !== 0) begin n_fail++; $display("FAIL stop_err other strobes: dv %0d pe %0d expected 0 0", dv_total - b_dv, pe_total - b_pe); end
    n_cmp++; if (bus.p_data !== model_p_data) begin n_fail++; $display("FAIL stop_err p_data held: got %0h expected %0h", bus.p_data, model_p_data); end
  endtask

  task automatic test_glitch;
    int unsigned b_dv, b_pe, b_se;
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    samp_ps = 16;
    bus.prescale = 6'd16; bus.par_en = 1'b0;
    bus.rx_in = 1'b0;
    wait_cycles(3);
    bus.rx_in = 1'b1;
    wait_cycles(9);
    n_cmp++; if (bus.dat_samp_en !== 1'b0) begin n_fail++; $display("FAIL glitch idle_after_sample: dat_samp_en got %b expected 0", bus.dat_samp_en); end
    n_cmp++; if (bus.edge_cnt !== 5'd0) begin n_fail++; $display("FAIL glitch edge_cnt: got %0d expected 0", bus.edge_cnt); end
    wait_cycles(200);
    n_cmp++; if ((dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se) !== 0) begin n_fail++; $display("FAIL glitch strobes: got %0d expected 0", (dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se)); end
  endtask

  task automatic test_idle_noise;
    int unsigned b_dv, b_pe, b_se;
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    idle_noise = 1'b1;
    wait_cycles(100);
    idle_noise = 1'b0;
    wait_cycles(2);
    n_cmp++; if ((dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se) !== 0) begin n_fail++; $display("FAIL idle_noise strobes: got %0d expected 0", (dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se)); end
    n_cmp++; if (bus.dat_samp_en !== 1'b0 || bus.p_data !== model_p_data) begin n_fail++; $display("FAIL idle_noise state: dat_samp_en %b p_data %0h expected 0 %0h", bus.dat_samp_en, bus.p_data, model_p_data); end
  endtask

  task automatic test_illegal_prescale;
    logic [5:0] bad [0:2];
    int unsigned s0;
    int unsigned bound;
    bad[0] = 6'd0; bad[1] = 6'd40; bad[2] = 6'd63;
    bound = (DW + 3) * 64;
    for (int k = 0; k < 3; k++) begin
      s0 = start_cyc;
      samp_ps = int'(bad[k]);
      bus.prescale = bad[k];
      bus.par_en = 1'b1;
      bus.rx_in = 1'b0;
      wait_cycles(2);
      bus.rx_in = 1'b1;
      wait_cycles(1);
      n_cmp++; if (start_cyc === s0) begin n_fail++; $display("FAIL illegal%0d frame_started: got 0 expected 1", k); end
      for (int i = 0; i < int'(bound) && bus.dat_samp_en === 1'b1; i++) @(negedge clk);
      n_cmp++; if (bus.dat_samp_en !== 1'b0) begin n_fail++; $display("FAIL illegal%0d lockup: dat_samp_en got %b expected 0 within %0d cycles", k, bus.dat_samp_en, bound); end
      wait_cycles(4);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned b_dv;
    b_dv = dv_total;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_cycles(8);
    model_p_data = 8'h22;
    n_cmp++; if (dv_total - b_dv !== 2) begin n_fail++; $display("FAIL b2b data_valid count: got %0d expected 2", dv_total - b_dv); end
    n_cmp++; if (dv_log[b_dv[7:0]] !== 8'h11) begin n_fail++; $display("FAIL b2b first p_data: got %0h expected 11", dv_log[b_dv[7:0]]); end
    n_cmp++; if (dv_log[8'(b_dv + 1)] !== 8'h22) begin n_fail++; $display("FAIL b2b second p_data: got %0h expected 22", dv_log[8'(b_dv + 1)]); end
  endtask

  task automatic test_reset_mid_frame;
    int unsigned b_dv, b_pe, b_se;
    logic [DW-1:0] d;
    d = 8'hC3;
    samp_ps = 16;
    bus.prescale = 6'd16; bus.par_en = 1'b1; bus.par_typ = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
    drive_bit(d[4], 5);
    b_dv = dv_total; b_pe = pe_total; b_se = se_total;
    reset_n = 1'b0;
    #1;
    model_p_data = '0;
    n_cmp++; if (bus.dat_samp_en !== 1'b0 || bus.edge_cnt !== 5'd0) begin n_fail++; $display("FAIL midrst counters: dat_samp_en %b edge_cnt %0d expected 0 0", bus.dat_samp_en, bus.edge_cnt); end
    n_cmp++; if (bus.p_data !== model_p_data || {bus.data_valid, bus.par_err, bus.stp_err} !== 3'b000) begin n_fail++; $display("FAIL midrst outputs: p_data %0h strobes %b expected 0 000", bus.p_data, {bus.data_valid, bus.par_err, bus.stp_err}); end
    wait_cycles(2);
    bus.rx_in = 1'b1;
    reset_n = 1'b1;
    wait_cycles(200);
    n_cmp++; if ((dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se) !== 0) begin n_fail++; $display("FAIL midrst aborted strobes: got %0d expected 0", (dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se)); end
    b_dv = dv_total;
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_cycles(6);
    model_p_data = 8'h5A;
    n_cmp++; if (dv_total - b_dv !== 1 || bus.p_data !== model_p_data) begin n_fail++; $display("FAIL midrst next frame: dv %0d p_data %0h expected 1 %0h", dv_total - b_dv, bus.p_data, model_p_data); end
  endtask

  task automatic test_random;
    logic [5:0] ps_tab [0:2];
    int unsigned b_dv, b_pe, b_se;
    int unsigned ps, exp_dv, exp_pe, exp_se;
    logic [DW-1:0] d;
    logic pe, pt, flip, stop;
    ps_tab[0] = PRESCALE_8; ps_tab[1] = PRESCALE_16; ps_tab[2] = PRESCALE_32;
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      ps   = int'(ps_tab[$urandom_range(0, 2)]);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 3) != 0);
      exp_pe = (pe && flip) ? 1 : 0;
      exp_se = stop ? 0 : 1;
      exp_dv = (exp_pe == 0 && exp_se == 0) ? 1 : 0;
      if (exp_dv == 1) model_p_data = d;
      b_dv = dv_total; b_pe = pe_total; b_se = se_total;
      send_frame(d, ps, pe, pt, flip, stop, 1'b1);
      wait_cycles($urandom_range(3, 10));
      n_cmp++; if (dv_total - b_dv !== exp_dv) begin n_fail++; $display("FAIL rand%0d data_valid count: got %0d expected %0d", k, dv_total - b_dv, exp_dv); end
      n_cmp++; if (pe_total - b_pe !== exp_pe) begin n_fail++; $display("FAIL rand%0d par_err count: got %0d expected %0d", k, pe_total - b_pe, exp_pe); end
      n_cmp++; if (se_total - b_se !== exp_se) begin n_fail++; $display("FAIL rand%0d stp_err count: got %0d expected %0d", k, se_total - b_se, exp_se); end
      n_cmp++; if (bus.p_data !== model_p_data) begin n_fail++; $display("FAIL rand%0d p_data: got %0h expected %0h", k, bus.p_data, model_p_data); end
      if (exp_dv == 1) begin
        n_cmp++; if (dv_cyc - start_cyc !== (2 + DW + int'(pe)) * ps) begin n_fail++; $display("FAIL rand%0d latency: got %0d expected %0d", k, dv_cyc - start_cyc, (2 + DW + int'(pe)) * ps); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    samp_ps = 16;
    idle_noise = 1'b0;
    model_p_data = '0;
    reset_n = 1'b0;
    bus.rx_in = 1'b1;
    bus.prescale = 6'd16;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;

    test_reset();
    test_no_parity();
    test_parity();
    test_stop_err();
    test_glitch();
    test_idle_noise();
    test_illegal_prescale();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
